// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer that lets N_REQ requesters share one
// unsigned divider.
//
// The arbiter picks a winner from req, latches its operands and starts the
// divider. It then returns the quotient to the winner with a one-cycle ack
// pulse. A zero divisor, or a divider that never answers, is answered locally
// with err=1, so no requester can stall forever.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   req         per-requester request level
//   a_in, b_in  packed dividends/divisors, requester i at [i*WIDTH +: WIDTH]
//   ack         one-hot, one-cycle completion pulse
//   result      quotient, meaningful while ack is nonzero
//   err         with ack: divide-by-zero or divider timeout
//   busy        high whenever the sequencer is not idle
//   div_init    one-cycle start pulse to the divider
//   div_A/div_B latched operands to the divider
//   div_result  quotient from the divider
//   div_done    divider completion, honoured only while waiting
module div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       result,
  output logic                   err,
  output logic                   busy,
  output logic                   div_init,
  output logic [WIDTH-1:0]       div_A,
  output logic [WIDTH-1:0]       div_B,
  input  logic [WIDTH-1:0]       div_result,
  input  logic                   div_done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] ID_LAST  = PTR_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] id;
  logic [CNT_W-1:0] cnt;

  logic             grant_vld;
  logic [PTR_W-1:0] grant_id;
  logic [PTR_W-1:0] grant_next;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  int               idx;

  // Round-robin search: first set request bit at or above rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_vld && req[PTR_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_id  = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    a_sel      = a_in[grant_id*WIDTH +: WIDTH];
    b_sel      = b_in[grant_id*WIDTH +: WIDTH];
    grant_next = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      id       <= '0;
      cnt      <= '0;
      ack      <= '0;
      result   <= '0;
      err      <= 1'b0;
      div_init <= 1'b0;
      div_A    <= '0;
      div_B    <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            id     <= grant_id;
            rr_ptr <= grant_next;
            div_A  <= a_sel;
            div_B  <= b_sel;
            // The start pulse is raised on entry to ISSUE so it is high for
            // exactly the ISSUE cycle; a zero divisor never starts the divider.
            div_init <= (b_sel != '0);
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          div_init <= 1'b0;
          cnt      <= '0;
          if (div_B == '0) begin
            result <= '1;
            err    <= 1'b1;
            ack    <= ONE_HOT0 << id;
            state  <= RESP;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          cnt <= cnt + 1'b1;
          // div_done takes priority over a timeout landing in the same cycle.
          if (div_done) begin
            result <= div_result;
            err    <= 1'b0;
            ack    <= ONE_HOT0 << id;
            state  <= RESP;
          end else if (cnt == CNT_LAST) begin
            result <= '0;
            err    <= 1'b1;
            ack    <= ONE_HOT0 << id;
            state  <= RESP;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter with a behavioural divider
// that answers a programmable number of cycles after its start pulse.
module tb_div_arbiter;

  localparam int N_REQ   = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       result;
  logic                   err;
  logic                   busy;
  logic                   div_init;
  logic [WIDTH-1:0]       div_A;
  logic [WIDTH-1:0]       div_B;
  logic [WIDTH-1:0]       div_result;
  logic                   div_done;

  int total = 0;
  int bad   = 0;

  // Divider model state
  logic             mdl_en;
  int               mdl_dly;
  logic             mdl_active;
  int               mdl_cnt;
  logic [WIDTH-1:0] mdl_a;
  logic [WIDTH-1:0] mdl_b;
  logic             mdl_done;
  logic [WIDTH-1:0] mdl_res;
  logic             force_done;
  logic [WIDTH-1:0] force_res;

  assign div_done   = mdl_done | force_done;
  assign div_result = force_done ? force_res : mdl_res;

  div_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .result(result), .err(err), .busy(busy),
    .div_init(div_init), .div_A(div_A), .div_B(div_B),
    .div_result(div_result), .div_done(div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done appears mdl_dly cycles after the cycle in which div_init is high
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (mdl_active) begin
      if (mdl_cnt == 1) begin
        mdl_done   <= 1'b1;
        mdl_res    <= (mdl_b == 0) ? '1 : mdl_a / mdl_b;
        mdl_active <= 1'b0;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
    if (div_init && mdl_en) begin
      mdl_active <= 1'b1;
      mdl_cnt    <= mdl_dly - 1;
      mdl_a      <= div_A;
      mdl_b      <= div_B;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int limit, output int n);
    n = 0;
    while (ack === '0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  int n;
  logic seen;

  initial begin
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    mdl_en = 1'b1; mdl_dly = 18; mdl_active = 1'b0; mdl_cnt = 0;
    mdl_a = '0; mdl_b = '0; mdl_done = 1'b0; mdl_res = '0;
    force_done = 1'b0; force_res = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_ack", ack, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_init", div_init, 0);
    chk("rst_div_A", div_A, 0);
    chk("rst_div_B", div_B, 0);

    // Single request: 100 / 7, divider answers 18 cycles after init
    set_op(0, 16'd100, 16'd7);
    req = 4'b0001;
    tick();
    chk("single_div_init", div_init, 1);
    chk("single_div_A", div_A, 100);
    chk("single_div_B", div_B, 7);
    chk("single_busy", busy, 1);
    tick();
    chk("single_init_pulse", div_init, 0);
    wait_ack(40, n);
    chk("single_latency", n, 18);
    chk("single_ack", ack, 4'b0001);
    chk("single_result", result, 14);
    chk("single_err", err, 0);
    req = '0;
    tick();
    chk("single_ack_pulse", ack, 0);
    chk("single_idle", busy, 0);

    // Round robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_op(i, WIDTH'(i + 10), 16'd1);
    mdl_dly = 3;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [N_REQ-1:0] exp_ack;
      exp_ack = '0;
      exp_ack[k % N_REQ] = 1'b1;
      wait_ack(20, n);
      chk("rr_ack", ack, exp_ack);
      chk("rr_result", result, 10 + (k % N_REQ));
      if (k == 4) req = '0;
      tick();
    end
    chk("rr_idle", busy, 0);

    // Divide by zero on requester 2
    set_op(2, 16'd500, 16'd0);
    req = 4'b0100;
    tick();
    chk("dz_busy1", busy, 1);
    chk("dz_init1", div_init, 0);
    chk("dz_ack1", ack, 0);
    tick();
    chk("dz_busy2", busy, 1);
    chk("dz_init2", div_init, 0);
    chk("dz_ack", ack, 4'b0100);
    chk("dz_result", result, 16'hFFFF);
    chk("dz_err", err, 1);
    req = '0;
    tick();
    chk("dz_idle", busy, 0);

    // Timeout on requester 1: divider never answers
    mdl_en = 1'b0;
    set_op(1, 16'd50, 16'd5);
    req = 4'b0010;
    tick();
    chk("to_div_init", div_init, 1);
    wait_ack(100, n);
    chk("to_latency", n, 65);
    chk("to_ack", ack, 4'b0010);
    chk("to_err", err, 1);
    chk("to_result", result, 0);
    req = '0;
    tick();
    mdl_en = 1'b1;
    mdl_dly = 5;
    set_op(3, 16'd81, 16'd9);
    req = 4'b1000;
    wait_ack(30, n);
    chk("after_to_ack", ack, 4'b1000);
    chk("after_to_result", result, 9);
    chk("after_to_err", err, 0);
    req = '0;
    tick();

    // Reset during WAIT of requester 1
    mdl_dly = 20;
    set_op(1, 16'd60, 16'd6);
    req = 4'b0010;
    tick(); tick(); tick();
    chk("rw_in_wait", busy, 1);
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    chk("rw_ack", ack, 0);
    chk("rw_result", result, 0);
    chk("rw_err", err, 0);
    chk("rw_busy", busy, 0);
    chk("rw_div_A", div_A, 0);
    chk("rw_div_B", div_B, 0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (ack !== '0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("rw_stray_done_ignored", seen, 0);
    force_res = 16'd123; force_done = 1'b1;
    tick();
    force_done = 1'b0;
    tick();
    chk("rw_forced_done_ack", ack, 0);
    chk("rw_forced_done_result", result, 0);
    // A reset pointer favours requester 1 over 3
    set_op(3, 16'd1000, 16'd10);
    req = 4'b1010;
    wait_ack(40, n);
    chk("rw_ptr_ack", ack, 4'b0010);
    chk("rw_ptr_result", result, 10);
    req = 4'b1000;
    tick();
    wait_ack(40, n);
    chk("rw_req3_ack", ack, 4'b1000);
    chk("rw_req3_result", result, 100);
    chk("rw_req3_err", err, 0);
    req = '0;
    tick();

    // div_done in the final WAIT cycle beats the timeout
    mdl_dly = 64;
    set_op(0, 16'd77, 16'd7);
    req = 4'b0001;
    tick();
    wait_ack(100, n);
    chk("sim_latency", n, 65);
    chk("sim_ack", ack, 4'b0001);
    chk("sim_result", result, 11);
    chk("sim_err", err, 0);
    req = '0;
    tick();

    // Requester drops req during WAIT: ack still delivered
    mdl_dly = 10;
    set_op(2, 16'd90, 16'd9);
    req = 4'b0100;
    tick(); tick();
    req = '0;
    wait_ack(40, n);
    chk("drop_ack", ack, 4'b0100);
    chk("drop_result", result, 10);
    chk("drop_err", err, 0);
    tick();
    chk("drop_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
